q_dequant8: RTL and testbench
=============================

# q_dequant8

Streaming dequantizer for the NPU 8-bit quantized datapath. It converts the 8-bit quantized results produced by the quantized arithmetic blocks (multiply/add) back into signed 16-bit fixed-point values, using the frame's MIN/MAX range. It sits at the output of the quantized compute chain, before write-back or host readout. It is frame-oriented: a START pulse latches the range and the sample count, then samples stream through a fixed 3-cycle pipeline.

## Interface
- LEN_W, 16, width of the frame-length counter
- CLK  in  1  clock
- RESET_X  in  1  reset; synchronous, active-high
- START  in  1  one-cycle pulse; latches MIN_IN, MAX_IN and FRAME_LEN; honoured only in IDLE
- MIN_IN  in  16  signed range minimum
- MAX_IN  in  16  signed range maximum
- FRAME_LEN  in  LEN_W  number of samples in the frame
- INPUT_EN  in  1  Q_IN valid this cycle
- Q_IN  in  8  unsigned quantized sample
- OUTPUT_EN  out  1  D_OUT valid this cycle
- D_OUT  out  16  signed dequantized value
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  one-cycle pulse at frame completion
- ERR  out  1  sticky error flag; cleared by an accepted START

## Operation
- **States.**
  - IDLE: START goes to RUN. If FRAME_LEN == 0, go to DRAIN with nothing in flight.
  - RUN: each INPUT_EN=1 cycle accepts one sample and increments the count. When count reaches the latched length, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then return to IDLE.
- **Range.** range = MAX_IN − MIN_IN, computed 17-bit signed at START.
  - If negative: ERR=1 and range is forced to 0, so every output equals MIN.
- **Arithmetic.**
  - P = Q_IN × range (25-bit unsigned).
  - Quot = floor((P + 127) / 255); the division must be exact, no approximation error.
  - D_OUT = sat16(MIN + Quot).
  - Q=0 gives MIN; Q=255 gives MAX.
- **Inputs outside RUN.**
  - INPUT_EN in IDLE or DRAIN: the sample is dropped and ERR is set.
  - START in RUN or DRAIN: ignored, ERR unaffected.
- **Shared cycles.** START and INPUT_EN in the same IDLE cycle: the sample is dropped and ERR is set.
- **DONE.**
  - DONE coincides with the OUTPUT_EN of the last sample.
  - For FRAME_LEN=0, DONE fires the cycle after START, with no OUTPUT_EN.
- **Reset mid-operation.** Synchronous reset discards everything:
  - pipeline valids are cleared;
  - state returns to IDLE;
  - no DONE is produced.

## Timing
- **Reset values.** OUTPUT_EN=0, D_OUT=0, BUSY=0, DONE=0, ERR=0. Latched MIN, range and length are 0. State is IDLE.
- **Latency.** A sample accepted at edge k appears with OUTPUT_EN=1 after edge k+3.
  - Throughput is 1 sample/cycle.
  - Input gaps propagate unchanged as output bubbles.
- **Pipeline stages.**
  - S1: register P.
  - S2: register Quot.
  - S3: register D_OUT and OUTPUT_EN.
- **D_OUT hold.** D_OUT holds its last value while OUTPUT_EN=0.
- **Frame boundaries.**
  - START at edge s: BUSY=1 after edge s. The first sample can be accepted in cycle s+1.
  - The last sample accepted at edge k: state is DRAIN after edge k, DONE=1 and OUTPUT_EN=1 after edge k+3, BUSY=0 after edge k+4.
- **Length counter.** LEN_W bits; terminal compare is exact, so no wrap occurs within a frame.

## Structure
- **Shared package `q_pkg` holds:**
  - Q_LEVELS=255 and Q_ROUND=127;
  - state encodings IDLE/RUN/DRAIN;
  - the 16-bit saturation limits.
- **Sub-module `q_div255`.** Exact pipelined floor(x/255) for 25-bit x, one register stage, e.g. reciprocal multiply plus a correction step. It is reusable by the quantize side.

## Test plan
- **Full-scale frame.** MIN=−100, MAX=155, FRAME_LEN=4, Q=0,1,128,255 back-to-back → D_OUT=−100,−99,28,155 on consecutive cycles starting 3 cycles after the first accept; DONE with the 4th output.
- **Rounding.** MIN=0, MAX=1000, Q=1,254,255 → D_OUT=4,996,1000.
- **Inverted range.** MIN=10, MAX=5, FRAME_LEN=2, Q=200,7 → ERR=1 and D_OUT=10,10; the next valid START clears ERR.
- **Bubbles.** FRAME_LEN=3 with INPUT_EN pattern 1,0,0,1,1 → OUTPUT_EN pattern 1,0,0,1,1 delayed 3 cycles; DONE with the 3rd output.
- **Reset mid-frame.** After 2 of 4 samples, assert RESET_X for one cycle → next cycle OUTPUT_EN=0, BUSY=0, D_OUT=0; no DONE ever fires.
- **Zero length and stray input.** FRAME_LEN=0 → DONE the cycle after START with no OUTPUT_EN. INPUT_EN=1 while IDLE → ERR=1 and no output.

Source files
------------

// File: rtl/q_pkg.sv
// Shared definitions for the 8-bit quantized datapath (dequantize / quantize sides).
// Contents: datapath widths, quantization constants, FSM state encoding,
// 16-bit saturation limits and the sat16 helper.
package q_pkg;

  localparam int unsigned Q_W    = 8;   // quantized sample width
  localparam int unsigned D_W    = 16;  // fixed-point value width
  localparam int unsigned R_W    = 17;  // signed MAX-MIN difference
  localparam int unsigned P_W    = 25;  // Q * range product
  localparam int unsigned QUOT_W = 18;  // floor(x/255) for any 25-bit x
  localparam int unsigned SUM_W  = 19;  // MIN + Quot before saturation

  localparam int unsigned Q_LEVELS = 255;
  localparam int unsigned Q_ROUND  = 127;

  localparam logic signed [D_W-1:0] SAT_MAX = D_W'(32767);
  localparam logic signed [D_W-1:0] SAT_MIN = D_W'(-32768);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Clamp a wide signed sum into the signed 16-bit range.
  function automatic logic signed [D_W-1:0] sat16(input logic signed [SUM_W-1:0] v);
    logic signed [D_W-1:0] r;
    if (v > SUM_W'(SAT_MAX))      r = SAT_MAX;
    else if (v < SUM_W'(SAT_MIN)) r = SAT_MIN;
    else                          r = D_W'(v);
    return r;
  endfunction

endpackage

// File: rtl/q_dequant8_if.sv
// Frame/stream bus of the dequantizer.
// master: drives start, min_in, max_in, frame_len, input_en, q_in;
//         receives output_en, d_out, busy, done, err.
// slave : the dequantizer side (directions reversed).
interface q_dequant8_if
  import q_pkg::*;
#(
  parameter int unsigned LEN_W = 16
);

  logic                  start;
  logic signed [D_W-1:0] min_in;
  logic signed [D_W-1:0] max_in;
  logic [LEN_W-1:0]      frame_len;
  logic                  input_en;
  logic [Q_W-1:0]        q_in;
  logic                  output_en;
  logic signed [D_W-1:0] d_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, min_in, max_in, frame_len, input_en, q_in,
    input  output_en, d_out, busy, done, err
  );

  modport slave (
    input  start, min_in, max_in, frame_len, input_en, q_in,
    output output_en, d_out, busy, done, err
  );

endinterface

// File: rtl/q_div255.sv
// Exact floor(x/255) for 25-bit unsigned x with one register stage.
// Ports: clk, rst (sync, active-high), in_valid/x in; out_valid/quot registered out.
module q_div255
  import q_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [P_W-1:0]    x,
  output logic              out_valid,
  output logic [QUOT_W-1:0] quot
);

  localparam int unsigned MUL_W     = P_W + 9;
  localparam int unsigned REM_W     = P_W + 1;
  localparam int unsigned DIV_MAGIC = 257;  // ~2^16/255, estimate never exceeds the true quotient

  logic [QUOT_W-1:0] est_c;
  logic [REM_W-1:0]  rem_c;
  logic [QUOT_W-1:0] quot_c;

  // Reciprocal estimate undershoots by at most 3, so the remainder is < 4*255
  // and three threshold compares restore the exact quotient.
  always_comb begin
    est_c  = QUOT_W'((MUL_W'(x) * MUL_W'(DIV_MAGIC)) >> 16);
    rem_c  = REM_W'(x) - REM_W'(est_c) * REM_W'(Q_LEVELS);
    quot_c = est_c
           + QUOT_W'(rem_c >= REM_W'(Q_LEVELS))
           + QUOT_W'(rem_c >= REM_W'(2 * Q_LEVELS))
           + QUOT_W'(rem_c >= REM_W'(3 * Q_LEVELS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      quot      <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) quot <= quot_c;
    end
  end

endmodule

// File: rtl/q_dequant8.sv
// Streaming 8-bit -> signed 16-bit dequantizer over a START-latched MIN/MAX range.
// Ports: clk, reset_x (sync, active-high), bus (q_dequant8_if.slave):
//   start/min_in/max_in/frame_len frame setup, input_en/q_in sample stream,
//   output_en/d_out result stream, busy/done/err status.
module q_dequant8
  import q_pkg::*;
#(
  parameter int unsigned LEN_W = 16
)(
  input  logic         clk,
  input  logic         reset_x,
  q_dequant8_if.slave  bus
);

  state_t state_q, state_d;

  logic start_acc_c, accept_c, last_c, stray_c, pipe_empty_c;

  logic signed [R_W-1:0]   diff_c;
  logic signed [D_W-1:0]   min_q;
  logic [D_W-1:0]          range_q;
  logic [LEN_W-1:0]        len_q, cnt_q;

  logic                    s0_valid, s0_last;
  logic [Q_W-1:0]          s0_q;
  logic                    s1_valid, s1_last;
  logic [P_W-1:0]          s1_p;
  logic [P_W-1:0]          div_x_c;
  logic                    s2_valid, s2_last;
  logic [QUOT_W-1:0]       s2_quot;
  logic signed [SUM_W-1:0] sum_c;

  logic                    output_en_q, done_q, busy_q, err_q;
  logic signed [D_W-1:0]   d_out_q;

  assign bus.output_en = output_en_q;
  assign bus.d_out     = d_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset_x) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc_c) state_d = (bus.frame_len == '0) ? DRAIN : RUN;
      RUN:     if (last_c) state_d = DRAIN;
      DRAIN:   if (pipe_empty_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control decode
  always_comb begin
    start_acc_c  = 1'b0;
    accept_c     = 1'b0;
    last_c       = 1'b0;
    stray_c      = 1'b0;
    pipe_empty_c = !(s0_valid || s1_valid || s2_valid);
    case (state_q)
      IDLE: begin
        start_acc_c = bus.start;
        stray_c     = bus.input_en;
      end
      RUN: begin
        accept_c = bus.input_en;
        last_c   = bus.input_en && (cnt_q == len_q - LEN_W'(1));
      end
      DRAIN:   stray_c = bus.input_en;
      default: ;
    endcase
  end

  assign diff_c = R_W'(bus.max_in) - R_W'(bus.min_in);

  // Frame parameters, sample count and status flags
  always_ff @(posedge clk) begin
    if (reset_x) begin
      min_q   <= '0;
      range_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (start_acc_c) begin
        min_q   <= bus.min_in;
        // Inverted range collapses to zero so every sample maps to MIN.
        range_q <= diff_c[R_W-1] ? '0 : diff_c[D_W-1:0];
        len_q   <= bus.frame_len;
        cnt_q   <= '0;
        // A sample arriving alongside START is dropped and flagged.
        err_q   <= diff_c[R_W-1] | bus.input_en;
      end else begin
        if (accept_c) cnt_q <= cnt_q + LEN_W'(1);
        if (stray_c)  err_q <= 1'b1;
      end
    end
  end

  assign div_x_c = s1_p + P_W'(Q_ROUND);

  q_div255 u_div255 (
    .clk       (clk),
    .rst       (reset_x),
    .in_valid  (s1_valid),
    .x         (div_x_c),
    .out_valid (s2_valid),
    .quot      (s2_quot)
  );

  assign sum_c = SUM_W'(min_q) + $signed({1'b0, s2_quot});

  // Sample capture, S1 product, S3 output; the last-sample tag rides alongside for DONE
  always_ff @(posedge clk) begin
    if (reset_x) begin
      s0_valid    <= 1'b0;
      s0_last     <= 1'b0;
      s0_q        <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_p        <= '0;
      s2_last     <= 1'b0;
      output_en_q <= 1'b0;
      done_q      <= 1'b0;
      d_out_q     <= '0;
    end else begin
      s0_valid <= accept_c;
      s0_last  <= last_c;
      if (accept_c) s0_q <= bus.q_in;
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      if (s0_valid) s1_p <= P_W'(s0_q) * P_W'(range_q);
      s2_last     <= s1_last;
      output_en_q <= s2_valid;
      done_q      <= (s2_valid && s2_last) || (start_acc_c && (bus.frame_len == '0));
      if (s2_valid) d_out_q <= sat16(sum_c);
    end
  end

endmodule

// File: tb/tb_q_dequant8.sv
// Self-checking bench for q_dequant8: vector table, hand-written frame sequences
// and randomized frames against an arithmetic reference model.
module tb_q_dequant8;

  logic clk = 1'b0;
  logic reset_x;

  q_dequant8_if #(.LEN_W(16)) bus();

  q_dequant8 #(.LEN_W(16)) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_dout = 0;

  // Per-frame stimulus slots: one entry per cycle after START
  bit s_en[64];
  int s_q[64];
  int s_exp[64];
  int n_slots;

  typedef struct {
    int mn;
    int mx;
    int q;
    int exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_dq(input int mn, input int mx, input int q);
    int r;
    int v;
    r = mx - mn;
    if (r < 0) r = 0;
    v = mn + (q * r + 127) / 255;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue START, play the slots, and check every output each cycle until BUSY drops.
  task automatic run_frame(input string nm, input int mn, input int mx, input int len);
    int e_oe[80];
    int e_dv[80];
    int e_done[80];
    int acc;
    int last_t;
    int er;
    for (int t = 0; t < 80; t++) begin
      e_oe[t] = 0; e_dv[t] = 0; e_done[t] = 0;
    end
    acc = 0;
    last_t = 0;
    if (len == 0) e_done[0] = 1;
    for (int i = 0; i < n_slots; i++) begin
      if (s_en[i] && acc < len) begin
        acc++;
        e_oe[i+4] = 1;
        e_dv[i+4] = s_exp[i];
        if (acc == len) begin
          e_done[i+4] = 1;
          last_t = i + 4;
        end
      end
    end
    er = (mx < mn) ? 1 : 0;
    bus.min_in    = 16'(mn);
    bus.max_in    = 16'(mx);
    bus.frame_len = 16'(len);
    bus.input_en  = 1'b0;
    bus.start     = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int t = 0; t <= last_t + 2; t++) begin
      chk({nm, " output_en"}, int'(bus.output_en), e_oe[t]);
      if (e_oe[t] != 0) model_dout = e_dv[t];
      chk({nm, " d_out"}, int'(bus.d_out), model_dout);
      chk({nm, " done"}, int'(bus.done), e_done[t]);
      chk({nm, " busy"}, int'(bus.busy), (t <= last_t) ? 1 : 0);
      chk({nm, " err"}, int'(bus.err), er);
      if (t < n_slots) begin
        bus.input_en = s_en[t];
        bus.q_in     = 8'(s_q[t]);
      end else begin
        bus.input_en = 1'b0;
      end
      tick;
    end
  endtask

  task automatic set_slot(input int i, input bit en, input int q, input int exp);
    s_en[i]  = en;
    s_q[i]   = q;
    s_exp[i] = exp;
  endtask

  initial begin
    int mn, mx, len, acc, i, tmp;

    tbl[0]  = '{-100, 155, 0, -100};
    tbl[1]  = '{-100, 155, 1, -99};
    tbl[2]  = '{-100, 155, 128, 28};
    tbl[3]  = '{-100, 155, 255, 155};
    tbl[4]  = '{0, 1000, 1, 4};
    tbl[5]  = '{0, 1000, 254, 996};
    tbl[6]  = '{0, 1000, 255, 1000};
    tbl[7]  = '{10, 5, 200, 10};
    tbl[8]  = '{-32768, 32767, 255, 32767};
    tbl[9]  = '{-32768, 32767, 0, -32768};
    tbl[10] = '{-32768, 32767, 128, 128};
    tbl[11] = '{7, 7, 99, 7};

    reset_x       = 1'b1;
    bus.start     = 1'b0;
    bus.input_en  = 1'b0;
    bus.q_in      = '0;
    bus.min_in    = '0;
    bus.max_in    = '0;
    bus.frame_len = '0;
    tick;
    tick;
    chk("reset output_en", int'(bus.output_en), 0);
    chk("reset d_out", int'(bus.d_out), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset err", int'(bus.err), 0);
    reset_x = 1'b0;
    tick;

    // Single-sample frames from the vector table
    for (int k = 0; k < 12; k++) begin
      n_slots = 1;
      set_slot(0, 1'b1, tbl[k].q, tbl[k].exp);
      run_frame($sformatf("tbl%0d", k), tbl[k].mn, tbl[k].mx, 1);
    end

    // Full-scale back-to-back frame
    n_slots = 4;
    set_slot(0, 1'b1, 0, -100);
    set_slot(1, 1'b1, 1, -99);
    set_slot(2, 1'b1, 128, 28);
    set_slot(3, 1'b1, 255, 155);
    run_frame("fullscale", -100, 155, 4);

    // Inverted range: outputs pinned to MIN, ERR raised
    n_slots = 2;
    set_slot(0, 1'b1, 200, 10);
    set_slot(1, 1'b1, 7, 10);
    run_frame("inverted", 10, 5, 2);

    // Bubbles propagate; this valid START also clears ERR
    n_slots = 5;
    set_slot(0, 1'b1, 1, 4);
    set_slot(1, 1'b0, 0, 0);
    set_slot(2, 1'b0, 0, 0);
    set_slot(3, 1'b1, 254, 996);
    set_slot(4, 1'b1, 255, 1000);
    run_frame("bubbles", 0, 1000, 3);

    // Zero-length frame
    n_slots = 0;
    run_frame("zerolen", 3, 9, 0);

    // Stray sample in IDLE
    bus.input_en = 1'b1;
    bus.q_in     = 8'd50;
    tick;
    bus.input_en = 1'b0;
    chk("stray err", int'(bus.err), 1);
    for (int t = 0; t < 5; t++) begin
      chk("stray output_en", int'(bus.output_en), 0);
      chk("stray done", int'(bus.done), 0);
      tick;
    end

    // START with INPUT_EN in the same IDLE cycle: sample dropped, ERR set
    bus.min_in    = 16'(0);
    bus.max_in    = 16'(255);
    bus.frame_len = 16'(1);
    bus.start     = 1'b1;
    bus.input_en  = 1'b1;
    bus.q_in      = 8'd3;
    tick;
    bus.start    = 1'b0;
    bus.input_en = 1'b0;
    chk("shared err", int'(bus.err), 1);
    chk("shared busy", int'(bus.busy), 1);
    chk("shared output_en", int'(bus.output_en), 0);
    bus.input_en = 1'b1;
    bus.q_in     = 8'd77;
    tick;
    bus.input_en = 1'b0;
    tick;
    tick;
    chk("shared no early output", int'(bus.output_en), 0);
    tick;
    chk("shared output_en", int'(bus.output_en), 1);
    chk("shared d_out", int'(bus.d_out), 77);
    chk("shared done", int'(bus.done), 1);
    chk("shared err held", int'(bus.err), 1);
    tick;
    chk("shared busy end", int'(bus.busy), 0);
    model_dout = 77;

    // Reset after 2 of 4 samples
    bus.min_in    = 16'(0);
    bus.max_in    = 16'(255);
    bus.frame_len = 16'(4);
    bus.start     = 1'b1;
    tick;
    bus.start    = 1'b0;
    bus.input_en = 1'b1;
    bus.q_in     = 8'd10;
    tick;
    bus.q_in = 8'd20;
    tick;
    bus.input_en = 1'b0;
    reset_x      = 1'b1;
    tick;
    reset_x = 1'b0;
    model_dout = 0;
    chk("midreset output_en", int'(bus.output_en), 0);
    chk("midreset busy", int'(bus.busy), 0);
    chk("midreset d_out", int'(bus.d_out), 0);
    chk("midreset err", int'(bus.err), 0);
    for (int t = 0; t < 8; t++) begin
      tick;
      chk("midreset output_en", int'(bus.output_en), 0);
      chk("midreset done", int'(bus.done), 0);
    end

    // Randomized frames against the reference model
    for (int f = 0; f < 25; f++) begin
      mn = int'($urandom_range(0, 65535)) - 32768;
      mx = int'($urandom_range(0, 65535)) - 32768;
      if ((f % 5) != 0 && mx < mn) begin
        tmp = mn; mn = mx; mx = tmp;
      end
      len = int'($urandom_range(1, 8));
      acc = 0;
      i = 0;
      while (acc < len) begin
        s_en[i]  = ($urandom_range(0, 99) < 70);
        s_q[i]   = int'($urandom_range(0, 255));
        s_exp[i] = ref_dq(mn, mx, s_q[i]);
        if (s_en[i]) acc++;
        i++;
      end
      n_slots = i;
      run_frame($sformatf("rand%0d", f), mn, mx, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
